// File: rtl/alu_logical_ex_stage.sv
// Two-stage elastic execute wrapper around the logical/shift ALU: S1 registers the
// decoded op and operands, S2 registers the ALU result toward writeback.

module alu_logical_shift (
  input  logic [2:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    case (sel)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = a ^ b;
      3'b110:  y = a << shamt;
      3'b100:  y = $unsigned($signed(a) >>> shamt);
      3'b101:  y = a >> shamt;
      default: y = '0;
    endcase
  end
endmodule

module alu_logical_ex_stage #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] retired_cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_result_q, s2_result_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_err_q, s2_err_d;

  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  logic        s2_free, s1_adv, accept, consume;
  logic [2:0]  alu_sel;
  logic        op_err;
  logic [31:0] alu_out;

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign consume  = s2_valid_q && out_ready;

  always_comb begin
    alu_sel = 3'b000;
    op_err  = 1'b0;
    case (s1_op_q)
      3'd0:    alu_sel = 3'b000;
      3'd1:    alu_sel = 3'b001;
      3'd2:    alu_sel = 3'b010;
      3'd3:    alu_sel = 3'b110;
      3'd4:    alu_sel = 3'b100;
      3'd5:    alu_sel = 3'b101;
      default: op_err  = 1'b1;
    endcase
  end

  alu_logical_shift u_alu (
    .sel (alu_sel),
    .a   (s1_a_q),
    .b   (s1_b_q),
    .y   (alu_out)
  );

  // flush beats every load; data registers may keep stale contents behind a cleared valid
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_tag_d   = in_tag;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_tag_d    = s2_tag_q;
    s2_err_d    = s2_err_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_adv) begin
      s2_valid_d  = 1'b1;
      s2_result_d = op_err ? 32'h0 : alu_out;
      s2_tag_d    = s1_tag_q;
      s2_err_d    = op_err;
    end else if (consume) begin
      s2_valid_d = 1'b0;
    end
  end

  // a consume in the flush cycle still counts; the counter saturates rather than wraps
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (consume && (retired_cnt_q != {CNT_W{1'b1}})) begin
      retired_cnt_d = retired_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_op_q       <= '0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_tag_q      <= '0;
      s2_err_q      <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_op_q       <= s1_op_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_tag_q      <= s1_tag_d;
      s2_valid_q    <= s2_valid_d;
      s2_result_q   <= s2_result_d;
      s2_tag_q      <= s2_tag_d;
      s2_err_q      <= s2_err_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_tag     = s2_tag_q;
  assign out_err     = s2_err_q;
  assign retired_cnt = retired_cnt_q;
endmodule

// File: tb/tb_alu_logical_ex_stage.sv
// Directed bench for alu_logical_ex_stage: per-feature tasks with hand-computed
// expectations; a second instance with a 4-bit counter covers saturation.

module tb_alu_logical_ex_stage;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [2:0]       in_op = '0;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready, out_valid, out_err;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      retired_cnt;

  logic             in_ready4, out_valid4, out_err4;
  logic [31:0]      out_result4;
  logic [TAG_W-1:0] out_tag4;
  logic [3:0]       retired_cnt4;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_logical_ex_stage #(.TAG_W(TAG_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_err(out_err), .retired_cnt(retired_cnt)
  );

  alu_logical_ex_stage #(.TAG_W(TAG_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_tag(out_tag4), .out_err(out_err4), .retired_cnt(retired_cnt4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n   = 1'b1;
    exp_cnt = 0;
    #1;
  endtask

  task automatic test_reset();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h exp 0", out_result); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %h exp 0", out_tag); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b exp 0", out_err); end
    checks++; if (retired_cnt !== 16'h0) begin errors++; $display("FAIL reset_retired_cnt got %h exp 0", retired_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    $display("reset: outputs cleared, in_ready=%b", in_ready);
  endtask

  // single op with no backpressure: accepted, S1 one cycle later, out_valid two cycles later
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] exp_res, input logic exp_err);
    out_ready = 1'b1;
    drive(op, a, b, tag);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b exp 1", name, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early_out_valid got %b exp 0", name, out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid got %b exp 1", name, out_valid); end
    checks++; if (out_result !== exp_res) begin errors++; $display("FAIL %s out_result got %h exp %h", name, out_result, exp_res); end
    checks++; if (out_tag !== tag) begin errors++; $display("FAIL %s out_tag got %h exp %h", name, out_tag, tag); end
    checks++; if (out_err !== exp_err) begin errors++; $display("FAIL %s out_err got %b exp %b", name, out_err, exp_err); end
    $display("op %s: a=%h b=%h tag=%0d -> result=%h err=%b", name, a, b, tag, out_result, out_err);
    step();
    exp_cnt++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s retire_out_valid got %b exp 0", name, out_valid); end
    checks++; if (retired_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL %s retired_cnt got %0d exp %0d", name, retired_cnt, exp_cnt); end
  endtask

  task automatic test_basic_ops();
    run_op("and", 3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd1, 32'h00F0_00F0, 1'b0);
    run_op("or",  3'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2, 32'hFFF0_FFF0, 1'b0);
    run_op("xor", 3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3, 32'hFF00_FF00, 1'b0);
  endtask

  task automatic test_shifts();
    run_op("sll4",  3'd3, 32'h0000_0001, 32'h0000_0024, 5'd4, 32'h0000_0010, 1'b0);
    run_op("sra31", 3'd4, 32'h8000_0000, 32'h0000_001F, 5'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("srl31", 3'd5, 32'h8000_0000, 32'h0000_001F, 5'd6, 32'h0000_0001, 1'b0);
    run_op("srl0",  3'd5, 32'h1234_5678, 32'hFFFF_FFE0, 5'd7, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_illegal();
    run_op("illegal7", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'h0, 1'b1);
    run_op("illegal6", 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [6];
    logic [31:0] as [6];
    logic [31:0] bs [6];
    logic [31:0] rs [6];
    ops[0] = 3'd0; as[0] = 32'hFFFF_0000; bs[0] = 32'h1234_5678; rs[0] = 32'h1234_0000;
    ops[1] = 3'd1; as[1] = 32'hFFFF_0000; bs[1] = 32'h1234_5678; rs[1] = 32'hFFFF_5678;
    ops[2] = 3'd2; as[2] = 32'hFFFF_0000; bs[2] = 32'h1234_5678; rs[2] = 32'hEDCB_5678;
    ops[3] = 3'd3; as[3] = 32'h1234_5678; bs[3] = 32'h0000_0008; rs[3] = 32'h3456_7800;
    ops[4] = 3'd4; as[4] = 32'hF000_0000; bs[4] = 32'h0000_0004; rs[4] = 32'hFF00_0000;
    ops[5] = 3'd5; as[5] = 32'hF000_0000; bs[5] = 32'h0000_0004; rs[5] = 32'h0F00_0000;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) drive(ops[c], as[c], bs[c], 5'(c + 1));
      else in_valid = 1'b0;
      #1;
      if (c < 6) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream in_ready c=%0d got %b exp 1", c, in_ready); end
      end
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream out_valid c=%0d got %b exp 1", c, out_valid); end
        checks++; if (out_result !== rs[c-2]) begin errors++; $display("FAIL stream out_result c=%0d got %h exp %h", c, out_result, rs[c-2]); end
        checks++; if (out_tag !== 5'(c - 1)) begin errors++; $display("FAIL stream out_tag c=%0d got %0d exp %0d", c, out_tag, c - 1); end
        $display("stream: cycle %0d result=%h tag=%0d", c, out_result, out_tag);
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream early_out_valid c=%0d got %b exp 0", c, out_valid); end
      end
      step();
    end
    exp_cnt = 6;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream drained_out_valid got %b exp 0", out_valid); end
    checks++; if (retired_cnt !== 16'd6) begin errors++; $display("FAIL stream retired_cnt got %0d exp 6", retired_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(3'd0, 32'hAAAA_AAAA, 32'hFFFF_0000, 5'd7);
    step();
    drive(3'd1, 32'h0000_0001, 32'h0000_0002, 5'd8);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp in_ready_second got %b exp 1", in_ready); end
    step();
    drive(3'd2, 32'h0000_0005, 32'h0000_0003, 5'd9);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready_full c=%0d got %b exp 0", c, in_ready); end
      checks++; if (out_result !== 32'hAAAA_0000) begin errors++; $display("FAIL bp held_result c=%0d got %h exp aaaa0000", c, out_result); end
      checks++; if (out_tag !== 5'd7) begin errors++; $display("FAIL bp held_tag c=%0d got %0d exp 7", c, out_tag); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp in_ready_release got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    exp_cnt++;
    checks++; if (out_result !== 32'h0000_0003) begin errors++; $display("FAIL bp second_result got %h exp 00000003", out_result); end
    checks++; if (out_tag !== 5'd8) begin errors++; $display("FAIL bp second_tag got %0d exp 8", out_tag); end
    $display("bp: retired tag 7, now result=%h tag=%0d", out_result, out_tag);
    step();
    exp_cnt++;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp third_valid got %b exp 1", out_valid); end
    checks++; if (out_result !== 32'h0000_0006) begin errors++; $display("FAIL bp third_result got %h exp 00000006", out_result); end
    checks++; if (out_tag !== 5'd9) begin errors++; $display("FAIL bp third_tag got %0d exp 9", out_tag); end
    $display("bp: result=%h tag=%0d", out_result, out_tag);
    step();
    exp_cnt++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp drained_valid got %b exp 0", out_valid); end
    checks++; if (retired_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bp retired_cnt got %0d exp %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(3'd0, 32'hFFFF_FFFF, 32'h1111_1111, 5'd3);
    step();
    drive(3'd1, 32'h0000_0000, 32'h2222_2222, 5'd4);
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush precond_valid got %b exp 1", out_valid); end
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(3'd2, 32'h3333_3333, 32'h0, 5'd5);
    step();
    exp_cnt++;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready got %b exp 1", in_ready); end
    checks++; if (retired_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL flush retired_cnt got %0d exp %0d", retired_cnt, exp_cnt); end
    $display("flush: out_valid=%b in_ready=%b retired=%0d", out_valid, in_ready, retired_cnt);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush dropped_op_valid got %b exp 0", out_valid); end
    run_op("post_flush", 3'd2, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 5'd10, 32'hF0F0_F0F0, 1'b0);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(3'd1, 32'h1234_0000, 32'h0000_5678, 5'd11);
    step();
    drive(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid precond_valid got %b exp 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got %b exp 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL rst_mid out_result got %h exp 0", out_result); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL rst_mid out_tag got %0d exp 0", out_tag); end
    checks++; if (retired_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid retired_cnt got %0d exp 0", retired_cnt); end
    $display("rst_mid: async clear out_valid=%b retired=%0d", out_valid, retired_cnt);
    step();
    rst_n   = 1'b1;
    exp_cnt = 0;
    out_ready = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid no_partial got %b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(3'd1, 32'(i), 32'h0, 5'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    checks++; if (retired_cnt4 !== 4'hF) begin errors++; $display("FAIL sat retired_cnt4 got %h exp f", retired_cnt4); end
    checks++; if (retired_cnt !== 16'd20) begin errors++; $display("FAIL sat retired_cnt got %0d exp 20", retired_cnt); end
    $display("sat: cnt4=%h cnt16=%0d", retired_cnt4, retired_cnt);
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_shifts();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_logical_ex_stage.md
Name: alu_logical_ex_stage

Overview:
- Execute-stage wrapper that sits directly upstream of the logical/shift ALU.
- Accepts decoded logical ops from issue over a valid/ready handshake.
- Registers the operands and drives the ALU's three select lines from a registered op code.
- Captures the ALU result into an output register toward writeback. It is a 2-stage elastic pipeline with full backpressure and flush.

Parameters:
- TAG_W, 5, width of destination-register tag carried alongside each op
- CNT_W, 16, width of the retired-op counter

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline kill
- in_valid  input  1  issue presents an op
- in_ready  output  1  stage can accept an op this cycle
- in_op  input  3  0=AND 1=OR 2=XOR 3=SLL 4=SRA 5=SRL, 6..7 illegal
- in_a  input  32  operand 1 (value to shift for shifts)
- in_b  input  32  operand 2 (shift amount in in_b[4:0] for shifts)
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  result register holds a result
- out_ready  input  1  writeback consumes result
- out_result  output  32  ALU result
- out_tag  output  TAG_W  tag of the result
- out_err  output  1  op was illegal
- retired_cnt  output  CNT_W  count of results consumed

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0, out_err=0, retired_cnt=0, all operand registers 0. in_ready=1 as soon as reset is released.
- Stage S1 (operand register) holds op, a, b, tag and valid.
- Decode from the registered op to ALU selects {sel2,sel1,sel0}:
  - AND=000, OR=001, XOR=010, SLL=110, SRA=100, SRL=101.
  - Illegal op drives 000 and sets the err bit.
- The ALU is instantiated combinationally between S1 and S2.
- Stage S2 (result register) holds result, tag, err and valid. It drives out_* directly, with no combinational path from in_* to out_*.
- Advance rules:
  - s2_free = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free. This is combinational from out_ready; no path from in_valid to in_ready.
- S1 loads when in_valid & in_ready. Otherwise s1_valid clears when s1_adv.
- S2 loads when s1_adv, storing result = err ? 0 : alu_out. Otherwise s2_valid clears when out_valid & out_ready.
- Latency: an op accepted in cycle N shows out_valid in cycle N+2 if there is no backpressure.
- Throughput: 1 op/cycle sustained while out_ready=1.
- Backpressure with out_ready held low: S2 holds, then S1 holds, then in_ready=0 with 2 ops buffered. Data in both stages must be stable and must not be overwritten. The held S1 op must issue the cycle after out_ready rises.
- Simultaneous accept + advance in S1: the new op loads and the old op moves to S2 in the same cycle.
- Simultaneous consume + load in S2: the old result retires and the new result loads. out_valid stays 1.
- Shifts:
  - Shift amount is in_b[4:0]; in_b[31:5] is ignored.
  - Amount 0 returns in_a unchanged.
  - SRA replicates in_a[31].
- flush (synchronous, higher priority than all loads): next edge s1_valid=0 and s2_valid=0. An op presented with in_valid in the flush cycle is dropped.
  - retired_cnt still counts a result consumed (out_valid & out_ready) in the flush cycle.
  - Data registers may keep stale values, but out_valid=0.
- retired_cnt increments on each out_valid & out_ready cycle and saturates at all-ones; it does not wrap. Illegal-op results count.
- Reset asserted mid-operation clears everything immediately, with no partial result emitted.

Test Plan:
- Basic ops:
  - AND a=F0F0_F0F0 b=0FF0_0FF0 with out_ready=1 -> 2 cycles later out_result=00F0_00F0, tag echoed, err=0.
  - OR of the same operands -> FFF0_FFF0.
  - XOR of the same operands -> FF00_FF00.
- Shifts:
  - SLL a=0000_0001 b=0000_0024 (amount 4) -> 0000_0010.
  - SRA a=8000_0000 b=1F -> FFFF_FFFF.
  - SRL a=8000_0000 b=1F -> 0000_0001.
  - SRL with amount 0 -> a unchanged.
- Streaming: 6 back-to-back ops, out_ready=1 -> results on 6 consecutive cycles, in order, retired_cnt=6.
- Backpressure: out_ready=0 while 3 ops are offered.
  - Required: in_ready drops after 2 accepted, out_result stable.
  - Raise out_ready -> the 3rd op is accepted the next cycle, all 3 retire in order, none lost or duplicated.
- Illegal op 7 with a=FFFF_FFFF -> out_result=0, out_err=1, retired_cnt increments.
- Flush and reset:
  - Flush with both stages full -> out_valid=0 next cycle, in_ready=1, a new op afterward completes normally.
  - rst_n pulsed low mid-stream -> all outputs 0 asynchronously.
- Saturation: force CNT_W=4, retire 20 ops -> retired_cnt stays at F.
